// File: rtl/accel_cmd_sequencer.sv
// Command-list write master: streams a host-loaded byte buffer into the
// Accelerator command register, one AW/W/B transaction per byte, then waits for RenderEnd.
module accel_cmd_sequencer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] CMD_ADDR   = 8'h01,
  parameter int                    PTR_W      = 6,
  parameter int                    TIMEOUT    = 1023
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    hWE,
  input  logic [PTR_W-1:0]        hADDR,
  input  logic [DATA_WIDTH-1:0]   hDATA,
  input  logic [PTR_W:0]          hLEN,
  input  logic                    hSTART,
  output logic                    oBusy,
  output logic                    oDone,
  output logic                    oError,
  output logic                    oTimeout,
  output logic [ADDR_WIDTH-1:0]   oAWADDR,
  output logic [2:0]              oAWPROT,
  output logic                    oAWVALID,
  input  logic                    iAWREADY,
  output logic [DATA_WIDTH-1:0]   oWDATA,
  output logic [DATA_WIDTH/8-1:0] oWSTRB,
  output logic                    oWVALID,
  input  logic                    iWREADY,
  output logic                    oBREADY,
  input  logic [1:0]              iBRESP,
  input  logic                    iBVALID,
  input  logic                    iRenderEnd
);

  localparam int DEPTH = 1 << PTR_W;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]  DEPTH_LEN = {1'b1, {PTR_W{1'b0}}};
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]       state_reg;
  logic [PTR_W-1:0] index_reg;
  logic [PTR_W:0]   len_reg;
  logic [WD_W-1:0]  wdog_reg;
  logic             aw_done_reg;
  logic             w_done_reg;

  logic [PTR_W:0] len_clamped;
  logic           last_byte;
  logic           aw_hs;
  logic           w_hs;

  assign oAWADDR = CMD_ADDR;
  assign oAWPROT = 3'b010;
  assign oWSTRB  = '1;

  assign len_clamped = (hLEN > DEPTH_LEN) ? DEPTH_LEN : hLEN;
  assign last_byte   = ({1'b0, index_reg} == (len_reg - 1'b1));
  assign aw_hs       = oAWVALID & iAWREADY;
  assign w_hs        = oWVALID & iWREADY;

  // Host writes are locked out while a list is in flight so the list stays stable.
  always_ff @(posedge ACLK) begin
    if (hWE && !oBusy)
      mem[hADDR] <= hDATA;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg   <= S_IDLE;
      index_reg   <= '0;
      len_reg     <= '0;
      wdog_reg    <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      oAWVALID    <= 1'b0;
      oWVALID     <= 1'b0;
      oBREADY     <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oError      <= 1'b0;
      oTimeout    <= 1'b0;
      oWDATA      <= '0;
    end else begin
      oDone <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (hSTART) begin
            oError    <= 1'b0;
            oTimeout  <= 1'b0;
            index_reg <= '0;
            len_reg   <= len_clamped;
            if (hLEN == '0) begin
              oDone     <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              oBusy     <= 1'b1;
              state_reg <= S_LOAD;
            end
          end
        end
        // The buffer read register is oWDATA itself, so data and valids rise together.
        S_LOAD: begin
          oWDATA      <= mem[index_reg];
          oAWVALID    <= 1'b1;
          oWVALID     <= 1'b1;
          aw_done_reg <= 1'b0;
          w_done_reg  <= 1'b0;
          state_reg   <= S_XFER;
        end
        S_XFER: begin
          if (aw_hs) begin
            oAWVALID    <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            oWVALID    <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
            oBREADY   <= 1'b1;
            state_reg <= S_RESP;
          end
        end
        S_RESP: begin
          if (iBVALID) begin
            oBREADY <= 1'b0;
            if (iBRESP != 2'b00) begin
              oError    <= 1'b1;
              oBusy     <= 1'b0;
              state_reg <= S_IDLE;
            end else if (last_byte) begin
              wdog_reg  <= '0;
              state_reg <= S_WAIT;
            end else begin
              index_reg <= index_reg + 1'b1;
              state_reg <= S_LOAD;
            end
          end
        end
        // Watchdog value k is visible k cycles after entry; abort lands TIMEOUT cycles in.
        S_WAIT: begin
          if (iRenderEnd) begin
            oDone     <= 1'b1;
            oBusy     <= 1'b0;
            state_reg <= S_DONE;
          end else if (wdog_reg == WD_LAST) begin
            oTimeout  <= 1'b1;
            oError    <= 1'b1;
            oBusy     <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_cmd_sequencer.sv
// Directed bench for accel_cmd_sequencer: a default-timeout instance drives the checks,
// a TIMEOUT=15 twin on the same inputs covers the watchdog.
module tb_accel_cmd_sequencer;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       hWE;
  logic [5:0] hADDR;
  logic [7:0] hDATA;
  logic [6:0] hLEN;
  logic       hSTART;
  logic       iAWREADY, iWREADY, iBVALID, iRenderEnd;
  logic [1:0] iBRESP;

  logic       oBusy, oDone, oError, oTimeout, oAWVALID, oWVALID, oBREADY;
  logic [7:0] oAWADDR, oWDATA;
  logic [2:0] oAWPROT;
  logic [0:0] oWSTRB;

  logic       w_busy, w_done, w_error, w_timeout, w_awvalid, w_wvalid, w_bready;
  logic [7:0] w_awaddr, w_wdata;
  logic [2:0] w_awprot;
  logic [0:0] w_wstrb;

  int checks = 0;
  int failures = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, busy_gaps = 0;
  bit track_busy = 0;
  logic [7:0] w_log [256];
  logic [7:0] list1 [10] = '{8'h50, 8'h50, 8'h00, 8'h00, 8'h01, 8'h07, 8'h30, 8'h30, 8'h70, 8'h70};
  int base_aw, base_w, base_b, base_done, wt, wsum;
  logic [7:0] exp_byte;

  always #5 ACLK = ~ACLK;

  accel_cmd_sequencer dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .hWE(hWE), .hADDR(hADDR), .hDATA(hDATA),
    .hLEN(hLEN), .hSTART(hSTART), .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oTimeout(oTimeout), .oAWADDR(oAWADDR), .oAWPROT(oAWPROT), .oAWVALID(oAWVALID),
    .iAWREADY(iAWREADY), .oWDATA(oWDATA), .oWSTRB(oWSTRB), .oWVALID(oWVALID),
    .iWREADY(iWREADY), .oBREADY(oBREADY), .iBRESP(iBRESP), .iBVALID(iBVALID),
    .iRenderEnd(iRenderEnd)
  );

  accel_cmd_sequencer #(.TIMEOUT(15)) dut_wd (
    .ACLK(ACLK), .ARESETn(ARESETn), .hWE(hWE), .hADDR(hADDR), .hDATA(hDATA),
    .hLEN(hLEN), .hSTART(hSTART), .oBusy(w_busy), .oDone(w_done), .oError(w_error),
    .oTimeout(w_timeout), .oAWADDR(w_awaddr), .oAWPROT(w_awprot), .oAWVALID(w_awvalid),
    .iAWREADY(iAWREADY), .oWDATA(w_wdata), .oWSTRB(w_wstrb), .oWVALID(w_wvalid),
    .iWREADY(iWREADY), .oBREADY(w_bready), .iBRESP(iBRESP), .iBVALID(iBVALID),
    .iRenderEnd(iRenderEnd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Records the handshakes of the current cycle, then advances to 1 time unit past the next edge.
  task automatic tick();
    if (oAWVALID && iAWREADY) aw_cnt++;
    if (oWVALID && iWREADY) begin
      w_log[w_cnt % 256] = oWDATA;
      w_cnt++;
    end
    if (oBREADY && iBVALID) b_cnt++;
    if (oDone) done_cnt++;
    if (track_busy && !oBusy) busy_gaps++;
    @(posedge ACLK);
    #1;
  endtask

  task automatic load_byte(input logic [5:0] a, input logic [7:0] d);
    hWE = 1'b1; hADDR = a; hDATA = d;
    tick();
    hWE = 1'b0;
  endtask

  task automatic start(input logic [6:0] len);
    hLEN = len; hSTART = 1'b1;
    tick();
    hSTART = 1'b0;
  endtask

  task automatic serve_byte(input int aw_wait, input int w_wait, input logic [1:0] bresp,
                            input logic [7:0] expv, output int waited);
    int c;
    logic aw_ok, w_ok, aw_now, w_now;
    waited = 0;
    while (!(oAWVALID && oWVALID) && waited < 20) begin
      tick();
      waited++;
    end
    chk("valids_up", {30'd0, oAWVALID, oWVALID}, 32'd3);
    chk("wdata", oWDATA, expv);
    chk("awaddr", oAWADDR, 8'h01);
    aw_ok = 1'b0; w_ok = 1'b0; c = 0;
    while (!(aw_ok && w_ok) && c < 20) begin
      aw_now = oAWVALID && (c >= aw_wait);
      w_now  = oWVALID && (c >= w_wait);
      iAWREADY = aw_now;
      iWREADY  = w_now;
      aw_ok = aw_ok | aw_now;
      w_ok  = w_ok | w_now;
      tick();
      c++;
      if (aw_now) chk("awvalid_drop", oAWVALID, 0);
      else if (!aw_ok) chk("awvalid_hold", oAWVALID, 1);
      if (w_now) chk("wvalid_drop", oWVALID, 0);
      else if (!w_ok) chk("wvalid_hold", oWVALID, 1);
    end
    iAWREADY = 1'b0; iWREADY = 1'b0;
    chk("bready", oBREADY, 1);
    iBVALID = 1'b1; iBRESP = bresp;
    tick();
    iBVALID = 1'b0; iBRESP = 2'b00;
  endtask

  initial begin
    ARESETn = 1'b0; hWE = 0; hADDR = 0; hDATA = 0; hLEN = 0; hSTART = 0;
    iAWREADY = 0; iWREADY = 0; iBVALID = 0; iBRESP = 0; iRenderEnd = 0;
    tick(); tick();
    chk("rst_awvalid", oAWVALID, 0);
    chk("rst_wvalid", oWVALID, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_flags", {oDone, oError, oTimeout, oBREADY}, 0);
    chk("rst_wdata", oWDATA, 0);
    chk("rst_const", {oAWADDR, oAWPROT, oWSTRB}, {8'h01, 3'b010, 1'b1});
    ARESETn = 1'b1;
    tick();

    // Ten-byte list, zero-wait slave, RenderEnd 20 cycles after the last B
    for (int i = 0; i < 10; i++) load_byte(6'(i), list1[i]);
    base_aw = aw_cnt; base_w = w_cnt; base_done = done_cnt;
    start(7'd10);
    chk("start_busy", oBusy, 1);
    chk("load_novalid", oAWVALID, 0);
    track_busy = 1;
    tick();
    chk("cycle2_valid", oAWVALID, 1);
    wsum = 0;
    for (int i = 0; i < 10; i++) begin
      serve_byte(0, 0, 2'b00, list1[i], wt);
      wsum += wt;
    end
    chk("zero_wait_gaps", wsum, 9);
    for (int i = 0; i < 20; i++) tick();
    chk("wait_no_done", done_cnt - base_done, 0);
    iRenderEnd = 1'b1;
    tick();
    iRenderEnd = 1'b0;
    track_busy = 0;
    chk("list1_done", oDone, 1);
    chk("list1_busy_fall", oBusy, 0);
    tick();
    chk("done_one_cycle", oDone, 0);
    chk("list1_done_count", done_cnt - base_done, 1);
    chk("list1_aw_count", aw_cnt - base_aw, 10);
    chk("list1_w_count", w_cnt - base_w, 10);
    chk("list1_busy_gaps", busy_gaps, 0);
    for (int i = 0; i < 10; i++) chk("list1_byte", w_log[(base_w + i) % 256], list1[i]);

    // Delayed AWREADY, then delayed WREADY
    base_b = b_cnt;
    start(7'd2);
    tick();
    serve_byte(3, 0, 2'b00, 8'h50, wt);
    serve_byte(0, 3, 2'b00, 8'h50, wt);
    chk("skew_b_count", b_cnt - base_b, 2);
    iRenderEnd = 1'b1;
    tick();
    iRenderEnd = 1'b0;
    chk("skew_done", oDone, 1);
    tick();

    // Error response on the third byte of six
    base_done = done_cnt;
    start(7'd6);
    tick();
    serve_byte(0, 0, 2'b00, 8'h50, wt);
    serve_byte(0, 0, 2'b00, 8'h50, wt);
    serve_byte(0, 0, 2'b10, 8'h00, wt);
    chk("bresp_error", oError, 1);
    chk("bresp_busy", oBusy, 0);
    chk("bresp_no_timeout", oTimeout, 0);
    base_aw = aw_cnt;
    for (int i = 0; i < 5; i++) tick();
    chk("bresp_no_more_aw", aw_cnt - base_aw, 0);
    chk("bresp_no_done", done_cnt - base_done, 0);
    start(7'd1);
    chk("restart_clears_error", oError, 0);
    tick();
    serve_byte(0, 0, 2'b00, 8'h50, wt);
    iRenderEnd = 1'b1;
    tick();
    iRenderEnd = 1'b0;
    chk("restart_done", oDone, 1);
    tick();

    // Watchdog (twin instance, TIMEOUT=15); RenderEnd during LOAD/XFER/RESP is ignored
    base_done = done_cnt;
    start(7'd2);
    iRenderEnd = 1'b1;
    tick();
    serve_byte(0, 0, 2'b00, 8'h50, wt);
    iRenderEnd = 1'b0;
    serve_byte(0, 0, 2'b00, 8'h50, wt);
    chk("early_end_ignored", done_cnt - base_done, 0);
    for (int i = 0; i < 14; i++) tick();
    chk("wd_not_yet", w_timeout, 0);
    tick();
    chk("wd_timeout", w_timeout, 1);
    chk("wd_error", w_error, 1);
    chk("wd_busy", w_busy, 0);
    chk("main_still_busy", oBusy, 1);
    chk("main_no_timeout", oTimeout, 0);
    iRenderEnd = 1'b1;
    tick();
    iRenderEnd = 1'b0;
    chk("main_late_done", oDone, 1);
    tick();

    // Zero-length list
    base_aw = aw_cnt;
    start(7'd0);
    chk("len0_done", oDone, 1);
    chk("len0_busy", oBusy, 0);
    tick();
    chk("len0_done_drop", oDone, 0);
    chk("len0_no_aw", aw_cnt - base_aw, 0);

    // hSTART and hWE while busy are ignored
    start(7'd3);
    hWE = 1'b1; hADDR = 6'd1; hDATA = 8'hEE; hLEN = 7'd5; hSTART = 1'b1;
    tick();
    hWE = 1'b0; hSTART = 1'b0;
    serve_byte(0, 0, 2'b00, 8'h50, wt);
    serve_byte(0, 0, 2'b00, 8'h50, wt);
    serve_byte(0, 0, 2'b00, 8'h00, wt);
    iRenderEnd = 1'b1;
    tick();
    iRenderEnd = 1'b0;
    chk("busy_ignore_done", oDone, 1);
    tick();

    // Asynchronous reset in XFER
    start(7'd2);
    tick();
    chk("pre_reset_valid", oAWVALID, 1);
    ARESETn = 1'b0;
    #1;
    chk("arst_valids", {oAWVALID, oWVALID, oBREADY}, 0);
    chk("arst_busy", oBusy, 0);
    chk("arst_wdata", oWDATA, 0);
    chk("arst_const", {oAWADDR, oAWPROT, oWSTRB}, {8'h01, 3'b010, 1'b1});
    tick();
    ARESETn = 1'b1;
    tick();
    start(7'd0);
    chk("arst_idle", oDone, 1);
    tick();

    // hLEN above the buffer depth is clamped to 64 bytes
    for (int i = 0; i < 64; i++) load_byte(6'(i), 8'(i) ^ 8'h3C);
    base_aw = aw_cnt;
    start(7'd100);
    tick();
    for (int i = 0; i < 64; i++) begin
      exp_byte = 8'(i) ^ 8'h3C;
      serve_byte(0, 0, 2'b00, exp_byte, wt);
    end
    tick();
    chk("clamp_stop", oAWVALID, 0);
    chk("clamp_aw_count", aw_cnt - base_aw, 64);
    iRenderEnd = 1'b1;
    tick();
    iRenderEnd = 1'b0;
    chk("clamp_done", oDone, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accel_cmd_sequencer.md
# accel_cmd_sequencer

Write-master front end for the Accelerator render engine. A host loads a command list (start point, count, object type byte, vertex coordinates) into an internal byte buffer, then pulses start. The block streams the list byte-by-byte into the Accelerator's AXI-lite-style slave write port, one AW/W/B transaction per byte, and waits for RenderEndInterrupt. It reports done, bus error, or watchdog timeout.

## Interface
- DATA_WIDTH, 8, command byte width; also sets the oWSTRB width (DATA_WIDTH/8)
- ADDR_WIDTH, 8, width of oAWADDR
- CMD_ADDR, 8'h01, fixed Accelerator command register address driven on oAWADDR
- PTR_W, 6, buffer index width; buffer depth is 2^PTR_W bytes
- TIMEOUT, 1023, maximum cycles spent in WAIT_END before a timeout abort

Ports:
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- hWE  in  1  host buffer write strobe
- hADDR  in  PTR_W  host buffer write index
- hDATA  in  DATA_WIDTH  host buffer write data
- hLEN  in  PTR_W+1  number of bytes to send; sampled on hSTART
- hSTART  in  1  start pulse
- oBusy  out  1  high from the cycle after an accepted hSTART until the cycle of oDone or an abort
- oDone  out  1  one-cycle pulse on successful completion
- oError  out  1  sticky: nonzero BRESP or timeout; cleared by the next accepted hSTART
- oTimeout  out  1  sticky: watchdog expired; cleared by the next accepted hSTART
- oAWADDR  out  ADDR_WIDTH  write address, always CMD_ADDR
- oAWPROT  out  3  always 3'b010
- oAWVALID  out  1  address valid
- iAWREADY  in  1  address ready
- oWDATA  out  DATA_WIDTH  command byte
- oWSTRB  out  DATA_WIDTH/8  always all ones
- oWVALID  out  1  data valid
- iWREADY  in  1  data ready
- oBREADY  out  1  response ready
- iBRESP  in  2  write response
- iBVALID  in  1  response valid
- iRenderEnd  in  1  RenderEndInterrupt from the Accelerator

## Operation
- Buffer: 2^PTR_W x DATA_WIDTH. Synchronous write on hWE only while oBusy=0; hWE while busy is ignored. Synchronous read, one-cycle latency. The buffer is not cleared by reset.
- States:
  - IDLE -> LOAD on hSTART with hLEN != 0; index <= 0; len <= hLEN; clears oError and oTimeout.
  - IDLE -> DONE on hSTART with hLEN = 0. No bus traffic.
  - LOAD: present the index to the buffer. -> XFER.
  - XFER: oAWVALID=oWVALID=1 and oWDATA=buf[index] on entry. Each valid drops the cycle after its own handshake (VALID&READY). Handshakes may occur in the same cycle or in either order. Flags aw_done and w_done track completion. -> RESP once both are complete.
  - RESP: oBREADY=1. On iBVALID:
    - iBRESP != 0: set oError, -> IDLE (abort).
    - iBRESP = 0 and index = len-1: -> WAIT_END.
    - iBRESP = 0 otherwise: index+1, -> LOAD.
  - WAIT_END: watchdog counts up from 0. On iRenderEnd -> DONE. If the count reaches TIMEOUT first, set oTimeout and oError, -> IDLE.
  - DONE: oDone=1 for one cycle. -> IDLE.
- iRenderEnd is ignored outside WAIT_END, including the cycle in which the last BVALID is accepted.
- hSTART is ignored unless the state is IDLE.
- hLEN > 2^PTR_W is clamped to 2^PTR_W. The index never wraps within a list.
- Valids, once asserted, are never withdrawn before their handshake (AXI rule).

## Timing
- All outputs are registered.
- Reset values:
  - oAWVALID, oWVALID, oBREADY, oBusy, oDone, oError, oTimeout = 0
  - oWDATA = 0
  - oAWADDR = CMD_ADDR, oAWPROT = 3'b010, oWSTRB = all ones
  - state = IDLE, index = 0, watchdog = 0
- Asserting ARESETn low mid-transaction drops all valids and oBREADY immediately and returns the block to IDLE.
- hSTART at cycle 0 gives: LOAD at cycle 1, valids high at cycle 2.
- With a zero-wait slave (readies high, BVALID the cycle after W), each byte takes 3 cycles: LOAD, XFER, RESP. N bytes take 3N cycles plus wait time, plus 1 cycle for DONE.
- oBusy falls in the same cycle oDone rises, or the cycle after an abort.

## Test plan
- Load 10 bytes {50,50,00,00,01,07,30,30,70,70}, hLEN=10, hSTART; slave always ready, BRESP=0; iRenderEnd 20 cycles after the last B -> exactly 10 AW/W handshakes carrying those bytes in order at address 8'h01; single oDone pulse; oBusy high throughout.
- iAWREADY delayed 3 cycles, iWREADY immediate (then the reverse) -> oWVALID drops after 1 cycle while oAWVALID holds; both valids never withdrawn early; still one B per byte.
- iBRESP=2'b10 on byte 3 of 6 -> oError=1, no further AW, return to IDLE, no oDone; the next hSTART clears oError.
- TIMEOUT=15, iRenderEnd never asserted -> oTimeout=oError=1 exactly 15 cycles after WAIT_END entry; iRenderEnd pulsed during XFER is ignored.
- hLEN=0 -> oDone exactly 1 cycle after hSTART, no bus traffic. hSTART and hWE while busy -> no effect on the list in flight or on buffer contents.
- ARESETn pulsed low during XFER -> valids drop at once, all outputs at reset values, the state is IDLE.
